srambank_ctrl_64x4x48: RTL and testbench



---
 rtl/srambank_ctrl_64x4x48.sv | 130 +++++++++++++
 tb/tb_srambank_ctrl_64x4x48.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/srambank_ctrl_64x4x48.sv
// Request-side controller for a single-port synchronous SRAM bank.
// Turns a valid/ready request stream into bank strobes. Read data is captured
// one cycle after issue and returned through a small in-order response FIFO.
// After reset it can zero-fill the bank before it accepts any traffic.
module srambank_ctrl_64x4x48 #(
  parameter int AW            = 8,
  parameter int DW            = 48,
  parameter int RESP_DEPTH    = 3,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_rdata,
  output logic          init_done,
  output logic [AW-1:0] sram_ADDRESS,
  output logic [DW-1:0] sram_wd,
  output logic          sram_banksel,
  output logic          sram_read,
  output logic          sram_write,
  input  logic [DW-1:0] sram_dataout
);

  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 2);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] ic_reg, ic_next;
  logic          pend_reg;
  logic [DW-1:0] fifo_mem [RESP_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] credit;
  logic          push, pop;

  // Reads in flight plus queued responses; this bounds new acceptances so the
  // FIFO can never overflow even when the client stops taking responses.
  assign credit = count_reg + CW'(pend_reg);

  // The captured word is exactly the bank output in the cycle after a read.
  assign push = pend_reg;
  assign pop  = resp_valid & resp_ready;

  assign resp_valid = (count_reg != '0) && !reset;
  assign resp_rdata = fifo_mem[rd_ptr_reg];
  assign init_done  = (state_reg == ST_RUN) && !(reset && INIT_ON_RESET);

  // State and zero-fill counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= INIT_ON_RESET ? ST_INIT : ST_RUN;
      ic_reg    <= '0;
    end else begin
      state_reg <= state_next;
      ic_reg    <= ic_next;
    end
  end

  // Next state, request acceptance and bank strobes; all quiet while in reset.
  always_comb begin
    state_next   = state_reg;
    ic_next      = ic_reg;
    req_ready    = 1'b0;
    sram_banksel = 1'b0;
    sram_read    = 1'b0;
    sram_write   = 1'b0;
    sram_ADDRESS = req_addr;
    sram_wd      = req_wdata;
    if (!reset) begin
      unique case (state_reg)
        ST_INIT: begin
          sram_banksel = 1'b1;
          sram_write   = 1'b1;
          sram_ADDRESS = ic_reg;
          sram_wd      = '0;
          ic_next      = ic_reg + AW'(1);
          if (ic_reg == '1) state_next = ST_RUN;
        end
        ST_RUN: begin
          req_ready = (credit < CW'(RESP_DEPTH));
          if (req_valid && req_ready) begin
            sram_banksel = 1'b1;
            sram_write   = req_write;
            sram_read    = ~req_write;
          end
        end
        default: state_next = state_reg;
      endcase
    end
  end

  // A read issued this cycle is captured on the following edge.
  always_ff @(posedge clk) begin
    if (reset) pend_reg <= 1'b0;
    else       pend_reg <= sram_read;
  end

  // Response FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= (wr_ptr_reg == PW'(RESP_DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= (rd_ptr_reg == PW'(RESP_DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
      if (push && !pop)      count_reg <= count_reg + CW'(1);
      else if (pop && !push) count_reg <= count_reg - CW'(1);
    end
  end

  // Response FIFO storage; contents need no reset since occupancy governs them.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= sram_dataout;
  end

  // The credit rule must keep a push from landing on a full FIFO.
  always_ff @(posedge clk) begin
    if (!reset && push && !pop) assert (count_reg < CW'(RESP_DEPTH));
  end

endmodule

// File: tb/tb_srambank_ctrl_64x4x48.sv
// Bench for srambank_ctrl_64x4x48: behavioural bank model, negedge monitor,
// and a scoreboard queue of expected read data in acceptance order.
module tb_srambank_ctrl_64x4x48;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [47:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [47:0] resp_rdata;
  logic        init_done;
  logic [7:0]  sram_ADDRESS;
  logic [47:0] sram_wd;
  logic        sram_banksel;
  logic        sram_read;
  logic        sram_write;
  logic [47:0] sram_dataout = '0;

  srambank_ctrl_64x4x48 dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .init_done(init_done),
    .sram_ADDRESS(sram_ADDRESS), .sram_wd(sram_wd), .sram_banksel(sram_banksel),
    .sram_read(sram_read), .sram_write(sram_write), .sram_dataout(sram_dataout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int stalls = 0;
  int resp_cnt = 0;
  int init_idx = 0;
  logic [47:0] bank [256];
  logic [47:0] ref_mem [256];
  logic [47:0] exp_q [$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bank model: synchronous single port; dataout holds junk unless just read.
  initial for (int i = 0; i < 256; i++) bank[i] = {16'hBAD0, 32'(i)};
  always @(posedge clk) begin
    if (sram_banksel && sram_write) bank[sram_ADDRESS] <= sram_wd;
    if (sram_banksel && sram_read) sram_dataout <= bank[sram_ADDRESS];
    else                           sram_dataout <= {16'hDEAD, $urandom};
  end

  // Monitor: init write sequence, run-time strobes, scoreboard.
  logic mon_hs;
  always @(negedge clk) begin
    if (!reset) begin
      if (!init_done && sram_write) begin
        check_val("init_addr", 64'(sram_ADDRESS), 64'(init_idx));
        check_val("init_wd", 64'(sram_wd), 64'd0);
        check_val("init_rd", 64'(sram_read), 64'd0);
        init_idx++;
      end
      if (init_done) begin
        mon_hs = req_valid && req_ready;
        check_val("banksel", 64'(sram_banksel), 64'(mon_hs));
        check_val("rd_strobe", 64'(sram_read), 64'(mon_hs && !req_write));
        check_val("wr_strobe", 64'(sram_write), 64'(mon_hs && req_write));
        if (mon_hs) check_val("addr", 64'(sram_ADDRESS), 64'(req_addr));
        if (mon_hs && req_write) check_val("wd", 64'(sram_wd), 64'(req_wdata));
      end
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) check_val("spurious_resp", 64'd1, 64'd0);
        else check_val("rdata", 64'(resp_rdata), 64'(exp_q.pop_front()));
        resp_cnt++;
      end
      if (init_done && req_valid && req_ready) begin
        if (req_write) ref_mem[req_addr] = req_wdata;
        else exp_q.push_back(ref_mem[req_addr]);
      end
    end
  end

  task automatic issue(input logic w, input logic [7:0] a, input logic [47:0] d);
    logic got;
    got = 1'b0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin got = 1'b1; break; end
      stalls++;
    end
    if (!got) check_val("issue_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    int n_cyc;
    @(posedge clk); #1;
    reset = 1'b1; req_valid = 1'b0; init_idx = 0;
    exp_q.delete();
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    @(negedge clk);
    check_val("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_val("rst_req_ready", 64'(req_ready), 64'd0);
    check_val("rst_strobes", {61'd0, sram_banksel, sram_read, sram_write}, 64'd0);
    check_val("rst_init_done", 64'(init_done), 64'd0);
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
    n_cyc = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (init_done) break;
      n_cyc++;
    end
    check_val("init_cycles", 64'(n_cyc), 64'd256);
    check_val("init_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    check_val("init_writes", 64'(init_idx), 64'd256);
  endtask

  int acc;
  int cnt0;
  logic hs;

  initial begin
    do_reset(3);

    // zero-filled word
    issue(1'b0, 8'h7F, '0);

    // write then read, with exact latency of the read
    issue(1'b1, 8'h10, 48'hA5A5_1234_5678);
    issue(1'b0, 8'h10, '0);
    @(negedge clk); check_val("lat_t1", 64'(resp_valid), 64'd0);
    @(negedge clk); check_val("lat_t2", 64'(resp_valid), 64'd1);
    @(posedge clk); #1;

    // 20 back-to-back reads with the client always ready
    for (int i = 0; i < 20; i++) issue(1'b1, 8'(8'h40 + i), {16'h5000, 32'(i * 7 + 1)});
    stalls = 0;
    cnt0 = resp_cnt;
    for (int i = 0; i < 20; i++) issue(1'b0, 8'(8'h40 + i), '0);
    check_val("b2b_stalls", 64'(stalls), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("b2b_resp_cnt", 64'(resp_cnt - cnt0), 64'd20);

    // backpressure: only three reads fit while responses are held
    resp_ready = 1'b0;
    acc = 0;
    req_valid = 1'b1; req_write = 1'b0;
    for (int c = 0; c < 8; c++) begin
      req_addr = 8'(8'h40 + acc);
      @(negedge clk); hs = req_ready;
      @(posedge clk); #1;
      if (hs) acc++;
    end
    req_addr = 8'(8'h40 + acc);
    check_val("bp_accepted", 64'(acc), 64'd3);
    @(negedge clk); check_val("bp_blocked", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk); check_val("bp_pop_cycle", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk); check_val("bp_reopen", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    issue(1'b0, 8'h44, '0);
    repeat (4) @(posedge clk); #1;

    // read, overwrite, read the same word
    issue(1'b1, 8'h05, 48'h0000_1111_2222);
    issue(1'b0, 8'h05, '0);
    issue(1'b1, 8'h05, 48'hFFFF_3333_4444);
    issue(1'b0, 8'h05, '0);
    repeat (4) @(posedge clk); #1;

    // reset with responses still queued
    resp_ready = 1'b0;
    issue(1'b0, 8'h10, '0);
    issue(1'b0, 8'h41, '0);
    repeat (2) @(posedge clk); #1;
    @(negedge clk); check_val("queued_before_rst", 64'(resp_valid), 64'd1);
    do_reset(1);
    resp_ready = 1'b1;
    repeat (6) @(posedge clk); #1;
    issue(1'b0, 8'h10, '0);

    // drain whatever is still expected
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1 check_val("drain_left", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
